// File: rtl/axi_4_lite_mst.sv
// AXI4-Lite master: turns single-beat local commands into AXI4-Lite write or
// read transactions and reports the outcome on a one-cycle response strobe.
module axi_4_lite_mst #(
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES   = 256
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          CMD_VALID,
  output logic                          CMD_READY,
  input  logic                          CMD_WRITE,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   CMD_ADDR,
  input  logic [C_AXI_DATA_WIDTH-1:0]   CMD_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] CMD_WSTRB,
  output logic                          RSP_VALID,
  output logic [C_AXI_DATA_WIDTH-1:0]   RSP_RDATA,
  output logic [1:0]                    RSP_RESP,
  output logic                          RSP_TIMEOUT,
  output logic                          BUSY,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP
);

  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int TW    = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // The timer holds cycles already spent waiting, so expiry is one short of the limit
  localparam logic [TW-1:0] TLAST = TW'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    DONE
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          expired;

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign expired      = TO_EN && (timer == TLAST);

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state         <= IDLE;
      timer         <= '0;
      CMD_READY     <= 1'b0;
      BUSY          <= 1'b0;
      RSP_VALID     <= 1'b0;
      RSP_RDATA     <= '0;
      RSP_RESP      <= 2'b00;
      RSP_TIMEOUT   <= 1'b0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          CMD_READY <= 1'b1;
          if (CMD_VALID && CMD_READY) begin
            CMD_READY <= 1'b0;
            BUSY      <= 1'b1;
            if (CMD_WRITE) begin
              M_AXI_AWADDR  <= CMD_ADDR;
              M_AXI_WDATA   <= CMD_WDATA;
              M_AXI_WSTRB   <= CMD_WSTRB;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              state         <= WR_REQ;
            end else begin
              M_AXI_ARADDR  <= CMD_ADDR;
              M_AXI_ARVALID <= 1'b1;
              state         <= RD_REQ;
            end
          end
        end

        // Address and data channels complete independently, in either order
        WR_REQ: begin
          if (M_AXI_AWVALID && M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WVALID && M_AXI_WREADY)   M_AXI_WVALID  <= 1'b0;
          if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
            M_AXI_BREADY <= 1'b1;
            timer        <= '0;
            state        <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            RSP_RESP     <= M_AXI_BRESP;
            RSP_RDATA    <= '0;
            RSP_TIMEOUT  <= 1'b0;
            RSP_VALID    <= 1'b1;
            state        <= DONE;
          end else if (expired) begin
            M_AXI_BREADY <= 1'b0;
            RSP_RESP     <= 2'b10;
            RSP_RDATA    <= '0;
            RSP_TIMEOUT  <= 1'b1;
            RSP_VALID    <= 1'b1;
            state        <= DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        RD_REQ: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            timer         <= '0;
            state         <= RD_DATA;
          end
        end

        // A data beat arriving on the expiry edge still completes normally
        RD_DATA: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            RSP_RDATA    <= M_AXI_RDATA;
            RSP_RESP     <= M_AXI_RRESP;
            RSP_TIMEOUT  <= 1'b0;
            RSP_VALID    <= 1'b1;
            state        <= DONE;
          end else if (expired) begin
            M_AXI_RREADY <= 1'b0;
            RSP_RDATA    <= '0;
            RSP_RESP     <= 2'b10;
            RSP_TIMEOUT  <= 1'b1;
            RSP_VALID    <= 1'b1;
            state        <= DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        DONE: begin
          RSP_VALID <= 1'b0;
          BUSY      <= 1'b0;
          CMD_READY <= 1'b1;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_4_lite_mst.sv
// Bench for axi_4_lite_mst: a configurable register slave on the bus, a word
// array reference model, directed scenarios and a randomized command stream.
module tb_axi_4_lite_mst;

  logic        clk;
  logic        rstn;
  logic        cmdValid, cmdReady, cmdWrite;
  logic [31:0] cmdAddr, cmdWdata;
  logic [3:0]  cmdWstrb;
  logic        rspValid, rspTimeout, busy;
  logic [31:0] rspRdata;
  logic [1:0]  rspResp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [2:0]  awprot, arprot;
  logic [1:0]  bresp, rresp;

  axi_4_lite_mst #(
    .C_AXI_ADDR_WIDTH(32),
    .C_AXI_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .M_AXI_ACLK(clk),
    .M_AXI_ARESETN(rstn),
    .CMD_VALID(cmdValid),
    .CMD_READY(cmdReady),
    .CMD_WRITE(cmdWrite),
    .CMD_ADDR(cmdAddr),
    .CMD_WDATA(cmdWdata),
    .CMD_WSTRB(cmdWstrb),
    .RSP_VALID(rspValid),
    .RSP_RDATA(rspRdata),
    .RSP_RESP(rspResp),
    .RSP_TIMEOUT(rspTimeout),
    .BUSY(busy),
    .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_AWADDR(awaddr),
    .M_AXI_AWPROT(awprot),
    .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready),
    .M_AXI_WDATA(wdata),
    .M_AXI_WSTRB(wstrb),
    .M_AXI_BVALID(bvalid),
    .M_AXI_BREADY(bready),
    .M_AXI_BRESP(bresp),
    .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_ARADDR(araddr),
    .M_AXI_ARPROT(arprot),
    .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready),
    .M_AXI_RDATA(rdata),
    .M_AXI_RRESP(rresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Slave configuration, set by the stimulus between commands
  int         awDelay = 0, wDelay = 0, arDelay = 0, bDelay = 0, rDelay = 0;
  bit         noResp = 1'b0;
  logic [1:0] respCode = 2'b00;

  logic [31:0] slvMem [64] = '{default: '0};
  int          awCnt, wCnt, arCnt, bCnt, rCnt;
  logic        awGot, wGot, arGot, bPend, rPend;
  logic [31:0] awAddrQ, wDataQ, arAddrQ;
  logic [3:0]  wStrbQ;

  assign awready = awvalid && (awCnt >= awDelay);
  assign wready  = wvalid  && (wCnt  >= wDelay);
  assign arready = arvalid && (arCnt >= arDelay);

  function automatic logic [31:0] slaveMerge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // Register slave: commits a write the cycle after both beats land, then
  // answers after bDelay/rDelay further cycles unless told to stay silent
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      awCnt <= 0; wCnt <= 0; arCnt <= 0; bCnt <= 0; rCnt <= 0;
      awGot <= 1'b0; wGot <= 1'b0; arGot <= 1'b0; bPend <= 1'b0; rPend <= 1'b0;
      awAddrQ <= '0; wDataQ <= '0; wStrbQ <= '0; arAddrQ <= '0;
      bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
    end else begin
      if (awvalid && awready) begin
        awGot <= 1'b1; awAddrQ <= awaddr; awCnt <= 0;
      end else if (awvalid) awCnt <= awCnt + 1;
      if (wvalid && wready) begin
        wGot <= 1'b1; wDataQ <= wdata; wStrbQ <= wstrb; wCnt <= 0;
      end else if (wvalid) wCnt <= wCnt + 1;
      if (bvalid && bready) bvalid <= 1'b0;
      if (awGot && wGot) begin
        slvMem[awAddrQ[7:2]] <= slaveMerge(slvMem[awAddrQ[7:2]], wDataQ, wStrbQ);
        awGot <= 1'b0; wGot <= 1'b0;
        if (!noResp) begin
          if (bDelay == 0) begin bvalid <= 1'b1; bresp <= respCode; end
          else begin bPend <= 1'b1; bCnt <= bDelay - 1; end
        end
      end
      if (bPend) begin
        if (bCnt == 0) begin bvalid <= 1'b1; bresp <= respCode; bPend <= 1'b0; end
        else bCnt <= bCnt - 1;
      end

      if (arvalid && arready) begin
        arGot <= 1'b1; arAddrQ <= araddr; arCnt <= 0;
      end else if (arvalid) arCnt <= arCnt + 1;
      if (rvalid && rready) rvalid <= 1'b0;
      if (arGot) begin
        arGot <= 1'b0;
        if (!noResp) begin
          if (rDelay == 0) begin
            rvalid <= 1'b1; rdata <= slvMem[arAddrQ[7:2]]; rresp <= respCode;
          end else begin rPend <= 1'b1; rCnt <= rDelay - 1; end
        end
      end
      if (rPend) begin
        if (rCnt == 0) begin
          rvalid <= 1'b1; rdata <= slvMem[arAddrQ[7:2]]; rresp <= respCode; rPend <= 1'b0;
        end else rCnt <= rCnt - 1;
      end
    end
  end

  // Bus monitor: records handshakes and counts AXI rule violations
  logic        prevAwv, prevAwr, prevWv, prevWr, prevArv, prevArr;
  logic        prevBready, prevRready, prevRsp;
  logic [31:0] prevAwaddr, prevWdata, prevAraddr;
  logic [3:0]  prevWstrb;
  int          protoErr = 0, monErr;
  int          awHsCount = 0, rspCount = 0;
  int          awHsCycle = 0, wHsCycle = 0, bRiseCycle = 0, rRiseCycle = 0;
  logic [31:0] busAwaddr = '0, busWdata = '0, busAraddr = '0;
  logic [3:0]  busWstrb = '0;

  always @(negedge clk) begin
    if (!rstn) begin
      prevAwv <= 1'b0; prevAwr <= 1'b0; prevWv <= 1'b0; prevWr <= 1'b0;
      prevArv <= 1'b0; prevArr <= 1'b0; prevBready <= 1'b0; prevRready <= 1'b0;
      prevRsp <= 1'b0; prevAwaddr <= '0; prevWdata <= '0; prevAraddr <= '0; prevWstrb <= '0;
    end else begin
      monErr = 0;
      if (prevAwv && !prevAwr && (!awvalid || awaddr != prevAwaddr)) monErr++;
      if (prevWv && !prevWr && (!wvalid || wdata != prevWdata || wstrb != prevWstrb)) monErr++;
      if (prevArv && !prevArr && (!arvalid || araddr != prevAraddr)) monErr++;
      if (prevAwv && prevAwr && awvalid) monErr++;
      if (prevWv && prevWr && wvalid) monErr++;
      if (prevArv && prevArr && arvalid) monErr++;
      if (bready && (awvalid || wvalid)) monErr++;
      if (rready && arvalid) monErr++;
      if (awprot != 3'b000 || arprot != 3'b000) monErr++;
      if (rspValid && prevRsp) monErr++;
      protoErr <= protoErr + monErr;
      if (awvalid && awready) begin
        awHsCount <= awHsCount + 1; awHsCycle <= cycleCnt; busAwaddr <= awaddr;
      end
      if (wvalid && wready) begin
        wHsCycle <= cycleCnt; busWdata <= wdata; busWstrb <= wstrb;
      end
      if (arvalid && arready) busAraddr <= araddr;
      if (bready && !prevBready) bRiseCycle <= cycleCnt;
      if (rready && !prevRready) rRiseCycle <= cycleCnt;
      if (rspValid) rspCount <= rspCount + 1;
      prevAwv <= awvalid; prevAwr <= awready; prevWv <= wvalid; prevWr <= wready;
      prevArv <= arvalid; prevArr <= arready; prevBready <= bready; prevRready <= rready;
      prevRsp <= rspValid; prevAwaddr <= awaddr; prevWdata <= wdata;
      prevAraddr <= araddr; prevWstrb <= wstrb;
    end
  end

  int          testsRun = 0, failCount = 0;
  logic [31:0] refMem [64] = '{default: '0};
  int          acceptCycle, lastRspCycle;
  logic        rspSeen;
  logic [31:0] gotRdata;
  logic [1:0]  gotResp;
  logic        gotTo;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic stepNeg();
    @(negedge clk);
    #1;
  endtask

  task automatic waitReady();
    for (int i = 0; i < 300 && !cmdReady; i++) stepNeg();
    checkOutput("cmd_ready_wait", 64'(cmdReady), 64'd1);
  endtask

  task automatic driveCmd(input logic w, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    waitReady();
    cmdWrite = w; cmdAddr = addr; cmdWdata = data; cmdWstrb = strb; cmdValid = 1'b1;
    acceptCycle = cycleCnt;
    stepNeg();
    cmdValid = 1'b0;
  endtask

  task automatic waitRsp();
    rspSeen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      stepNeg();
      if (rspValid) begin
        rspSeen = 1'b1; gotRdata = rspRdata; gotResp = rspResp; gotTo = rspTimeout;
        lastRspCycle = cycleCnt;
        break;
      end
    end
  endtask

  function automatic logic [31:0] strbMask(logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
    return m;
  endfunction

  // One command end to end; expectations come from the reference array and slave setup
  task automatic applyStimulus(input logic w, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input bit checkLat);
    logic [31:0] expRdata;
    logic [1:0]  expResp;
    logic        expTo;
    expTo    = noResp;
    expResp  = noResp ? 2'b10 : respCode;
    expRdata = (w || noResp) ? 32'h0 : refMem[addr[7:2]];
    driveCmd(w, addr, data, strb);
    waitRsp();
    checkOutput("rsp_seen", 64'(rspSeen), 64'd1);
    checkOutput(w ? "wr_resp" : "rd_resp", 64'(gotResp), 64'(expResp));
    checkOutput("rsp_timeout", 64'(gotTo), 64'(expTo));
    checkOutput(w ? "wr_rdata" : "rd_rdata", 64'(gotRdata), 64'(expRdata));
    if (w) begin
      checkOutput("bus_awaddr", 64'(busAwaddr), 64'(addr));
      checkOutput("bus_wdata", 64'(busWdata), 64'(data));
      checkOutput("bus_wstrb", 64'(busWstrb), 64'(strb));
      refMem[addr[7:2]] = (refMem[addr[7:2]] & ~strbMask(strb)) | (data & strbMask(strb));
    end else begin
      checkOutput("bus_araddr", 64'(busAraddr), 64'(addr));
    end
    if (checkLat) checkOutput("latency", 64'(lastRspCycle - acceptCycle), 64'd4);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int baseRsp, baseAw;
    logic w;
    logic [31:0] a;
    bit heldOk;

    cmdValid = 1'b0; cmdWrite = 1'b0; cmdAddr = '0; cmdWdata = '0; cmdWstrb = '0;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    repeat (3) stepNeg();
    checkOutput("rst_valids",
                64'({awvalid, wvalid, arvalid, bready, rready, rspValid, rspTimeout, busy}), 64'd0);
    checkOutput("rst_addr", 64'({awaddr, araddr}), 64'd0);
    checkOutput("rst_wdata_strb", 64'({wdata, wstrb}), 64'd0);
    checkOutput("rst_rsp", 64'({rspRdata, rspResp}), 64'd0);
    rstn = 1'b1;
    repeat (2) stepNeg();
    checkOutput("idle_ready", 64'({cmdReady, busy}), 64'b10);

    $display("[TB] write/read basic");
    baseRsp = rspCount;
    applyStimulus(1'b1, 32'h00, 32'hDEADBEEF, 4'b1111, 1'b1);
    applyStimulus(1'b0, 32'h00, 32'h0, 4'b0000, 1'b1);
    stepNeg();
    checkOutput("basic_rsp_pulses", 64'(rspCount - baseRsp), 64'd2);

    $display("[TB] partial strobe");
    applyStimulus(1'b1, 32'h14, 32'hFFFFFFFF, 4'b1111, 1'b1);
    applyStimulus(1'b1, 32'h14, 32'h00563400, 4'b0110, 1'b1);
    applyStimulus(1'b0, 32'h14, 32'h0, 4'b0000, 1'b1);
    checkOutput("strobe_value", 64'(gotRdata), 64'h00000000FF5634FF);

    $display("[TB] staggered AW/W ready");
    awDelay = 5; wDelay = 2;
    applyStimulus(1'b1, 32'h20, 32'h12345678, 4'b1111, 1'b0);
    checkOutput("aw_minus_w_hs", 64'(awHsCycle - wHsCycle), 64'd3);
    checkOutput("bready_after_both", 64'(bRiseCycle - awHsCycle), 64'd1);
    awDelay = 0; wDelay = 0;
    applyStimulus(1'b0, 32'h20, 32'h0, 4'b0000, 1'b1);

    $display("[TB] response timeouts");
    noResp = 1'b1;
    applyStimulus(1'b0, 32'h14, 32'h0, 4'b0000, 1'b0);
    checkOutput("rd_timeout_cycles", 64'(lastRspCycle - rRiseCycle), 64'd16);
    checkOutput("rd_timeout_rready", 64'(rready), 64'd0);
    applyStimulus(1'b1, 32'h30, 32'h0F0F0F0F, 4'b1111, 1'b0);
    checkOutput("wr_timeout_cycles", 64'(lastRspCycle - bRiseCycle), 64'd16);
    noResp = 1'b0;
    applyStimulus(1'b0, 32'h14, 32'h0, 4'b0000, 1'b1);
    applyStimulus(1'b0, 32'h30, 32'h0, 4'b0000, 1'b1);

    $display("[TB] command held while busy");
    baseRsp = rspCount; baseAw = awHsCount;
    waitReady();
    cmdWrite = 1'b1; cmdAddr = 32'h40; cmdWdata = 32'h0BADF00D; cmdWstrb = 4'hF; cmdValid = 1'b1;
    stepNeg();
    cmdAddr = 32'h7C; cmdWdata = 32'hA5A5A5A5;
    heldOk = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (cmdReady) begin
        stepNeg();
        heldOk = 1'b1;
        break;
      end
      stepNeg();
    end
    cmdValid = 1'b0;
    for (int i = 0; i < 300 && rspCount < baseRsp + 2; i++) stepNeg();
    repeat (4) stepNeg();
    checkOutput("held_accepted", 64'(heldOk), 64'd1);
    checkOutput("held_aw_count", 64'(awHsCount - baseAw), 64'd2);
    checkOutput("held_rsp_count", 64'(rspCount - baseRsp), 64'd2);
    checkOutput("held_last_addr", 64'(busAwaddr), 64'h7C);
    refMem[6'h10] = 32'h0BADF00D;
    refMem[6'h1F] = 32'hA5A5A5A5;
    applyStimulus(1'b0, 32'h7C, 32'h0, 4'b0000, 1'b1);
    applyStimulus(1'b0, 32'h40, 32'h0, 4'b0000, 1'b1);

    $display("[TB] reset during address phase");
    awDelay = 10;
    driveCmd(1'b1, 32'h50, 32'h11223344, 4'hF);
    for (int i = 0; i < 20 && !awvalid; i++) stepNeg();
    baseRsp = rspCount;
    #2 rstn = 1'b0;
    #1 checkOutput("mid_reset_drop", 64'({awvalid, wvalid, busy}), 64'd0);
    repeat (3) stepNeg();
    rstn = 1'b1;
    awDelay = 0;
    repeat (3) stepNeg();
    checkOutput("mid_reset_no_rsp", 64'(rspCount - baseRsp), 64'd0);
    applyStimulus(1'b1, 32'h50, 32'hCAFEF00D, 4'hF, 1'b1);
    applyStimulus(1'b0, 32'h50, 32'h0, 4'b0000, 1'b1);

    $display("[TB] randomized commands");
    for (int n = 0; n < 40; n++) begin
      int r;
      awDelay = $urandom_range(0, 3); wDelay = $urandom_range(0, 3);
      arDelay = $urandom_range(0, 3); bDelay = $urandom_range(0, 3);
      rDelay  = $urandom_range(0, 3);
      r = $urandom_range(0, 7);
      respCode = (r == 0) ? 2'b10 : (r == 1) ? 2'b11 : 2'b00;
      w = 1'($urandom_range(0, 1));
      a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      applyStimulus(w, a, $urandom, 4'($urandom_range(1, 15)),
                    (awDelay + wDelay + arDelay + bDelay + rDelay) == 0);
    end

    respCode = 2'b00;
    repeat (2) stepNeg();
    checkOutput("protocol_errors", 64'(protoErr), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
